// File: rtl/redirect_if.sv
// Handshake bundle between the execute stage, fetch and the redirect controller.
// The pipeline side is the master; the controller is the slave.
interface redirect_if;
  logic        ex_valid;
  logic        ex_branch;
  logic [63:0] ex_pc;
  logic [63:0] ex_jump;
  logic        ex_stall;
  logic        ibus_busy;
  logic        redirect_ready;
  logic        flush_o;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        busy_o;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  modport master (
    output ex_valid, ex_branch, ex_pc, ex_jump, ex_stall, ibus_busy, redirect_ready,
    input  flush_o, redirect_valid, redirect_pc, busy_o, branch_cnt, mispred_cnt
  );

  modport slave (
    input  ex_valid, ex_branch, ex_pc, ex_jump, ex_stall, ibus_busy, redirect_ready,
    output flush_o, redirect_valid, redirect_pc, busy_o, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/redirect_ctrl.sv
// Control-flow redirect controller: compares resolved EX outcome against pc+4,
// flushes younger work and holds a redirect until fetch is free to accept it.
module redirect_ctrl (
  input  logic      clk,
  input  logic      resetn,
  redirect_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, REDIR} state_t;

  state_t      state;
  logic        done;
  logic [63:0] target;
  logic [31:0] branch_q;
  logic [31:0] mispred_q;
  logic        idle;
  logic        fire;
  logic        mispred;

  // Branches seen outside IDLE are ignored: flush_o already kills them.
  assign idle    = (state == IDLE);
  assign fire    = bus.ex_valid & bus.ex_branch & ~done & idle;
  assign mispred = fire & (bus.ex_jump != (bus.ex_pc + 64'd4));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      done      <= 1'b0;
      target    <= 64'd0;
      branch_q  <= 32'd0;
      mispred_q <= 32'd0;
    end else begin
      // A stalled branch fires once, then is masked until it leaves EX.
      done <= bus.ex_stall & (done | fire);
      if (fire)    branch_q  <= branch_q + 32'd1;
      if (mispred) mispred_q <= mispred_q + 32'd1;
      case (state)
        IDLE: begin
          if (mispred) begin
            target <= bus.ex_jump;
            state  <= bus.ibus_busy ? WAIT : REDIR;
          end
        end
        WAIT:    if (!bus.ibus_busy)     state <= REDIR;
        REDIR:   if (bus.redirect_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.flush_o        = mispred | ~idle;
  assign bus.busy_o         = ~idle;
  assign bus.redirect_valid = (state == REDIR);
  assign bus.redirect_pc    = (state == REDIR) ? target : 64'd0;
  assign bus.branch_cnt     = branch_q;
  assign bus.mispred_cnt    = mispred_q;
endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: per-cycle checks plus a queue of expected
// redirect targets consumed whenever fetch accepts a redirect.
module tb_redirect_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic tb_done = 1'b0;
  logic [63:0] exp_q[$];

  redirect_if bus ();
  redirect_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid = 1'b0; bus.ex_branch = 1'b0; bus.ex_stall = 1'b0;
    bus.ex_pc = 64'd0; bus.ex_jump = 64'd0;
    bus.ibus_busy = 1'b0; bus.redirect_ready = 1'b1;
  endtask

  task automatic do_reset();
    step();
    resetn = 1'b0;
    idle_inputs();
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic drive_br(input logic [63:0] pc, input logic [63:0] jmp, input logic stall);
    bus.ex_valid = 1'b1; bus.ex_branch = 1'b1;
    bus.ex_pc = pc; bus.ex_jump = jmp; bus.ex_stall = stall;
  endtask

  // Reference for the one-shot flag of a stalled branch.
  always @(posedge clk)
    tb_done <= resetn & bus.ex_stall & (tb_done | (bus.ex_valid & bus.ex_branch));

  // Redirect acceptance pops the scoreboard; an unexpected redirect is an error.
  always @(negedge clk) begin
    if (resetn && bus.redirect_valid && bus.redirect_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (0) else begin
          errors++;
          $error("FAIL unexpected_redirect: observed pc %0h expected none", bus.redirect_pc);
        end
      end else begin
        check("redirect_pc_sb", bus.redirect_pc, exp_q.pop_front());
      end
    end
    if (resetn && bus.ex_valid && bus.ex_branch && !tb_done) begin
      assert (!bus.busy_o) else begin
        errors++;
        $error("FAIL fire_while_busy: observed busy %0b expected 0", bus.busy_o);
      end
    end
  end

  initial begin
    idle_inputs();
    // Reset with random inputs (ex_valid held low as the pipeline does).
    for (int i = 0; i < 3; i++) begin
      step();
      bus.ex_branch = 1'($urandom); bus.ex_stall = 1'($urandom);
      bus.ex_pc = {$urandom, $urandom}; bus.ex_jump = {$urandom, $urandom};
      bus.ibus_busy = 1'($urandom); bus.redirect_ready = 1'($urandom);
    end
    @(negedge clk);
    check("rst_flush", 64'(bus.flush_o), 64'd0);
    check("rst_rv", 64'(bus.redirect_valid), 64'd0);
    check("rst_pc", bus.redirect_pc, 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_bcnt", 64'(bus.branch_cnt), 64'd0);
    check("rst_mcnt", 64'(bus.mispred_cnt), 64'd0);
    step();
    resetn = 1'b1;
    idle_inputs();

    // Taken JAL with fetch idle.
    step();
    drive_br(64'h8000_0000, 64'h8000_0100, 1'b0);
    exp_q.push_back(64'h8000_0100);
    @(negedge clk);
    check("jal_flush_T", 64'(bus.flush_o), 64'd1);
    check("jal_rv_T", 64'(bus.redirect_valid), 64'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("jal_rv_T1", 64'(bus.redirect_valid), 64'd1);
    check("jal_pc_T1", bus.redirect_pc, 64'h8000_0100);
    step();
    @(negedge clk);
    check("jal_busy_T2", 64'(bus.busy_o), 64'd0);
    check("jal_flush_T2", 64'(bus.flush_o), 64'd0);
    check("jal_bcnt", 64'(bus.branch_cnt), 64'd1);
    check("jal_mcnt", 64'(bus.mispred_cnt), 64'd1);

    // Not-taken BZ.
    do_reset();
    drive_br(64'h1000, 64'h1004, 1'b0);
    @(negedge clk);
    check("bz_flush", 64'(bus.flush_o), 64'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("bz_rv", 64'(bus.redirect_valid), 64'd0);
    check("bz_bcnt", 64'(bus.branch_cnt), 64'd1);
    check("bz_mcnt", 64'(bus.mispred_cnt), 64'd0);

    // Mispredict while an ibus fetch is in flight (busy T-1..T+2).
    do_reset();
    bus.ibus_busy = 1'b1;
    step();
    begin
      int nflush = 0;
      for (int k = 0; k < 7; k++) begin
        if (k == 0) begin
          drive_br(64'h2000, 64'h3000, 1'b0);
          exp_q.push_back(64'h3000);
        end else begin
          bus.ex_valid = 1'b0; bus.ex_branch = 1'b0;
        end
        bus.ibus_busy = (k < 3);
        @(negedge clk);
        nflush += int'(bus.flush_o);
        check($sformatf("busy_rv_%0d", k), 64'(bus.redirect_valid), 64'(k == 4));
        check($sformatf("busy_flush_%0d", k), 64'(bus.flush_o), 64'(k <= 4));
        step();
      end
      check("busy_nflush", 64'(nflush), 64'd5);
    end

    // Stalled mispredict: stall for 3 cycles, fetch refuses for 2.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive_br(64'h4000, 64'h4800, (k < 3));
      else idle_inputs();
      if (k == 0) exp_q.push_back(64'h4800);
      bus.redirect_ready = !(k == 1 || k == 2);
      @(negedge clk);
      check($sformatf("stall_rv_%0d", k), 64'(bus.redirect_valid), 64'(k >= 1 && k <= 3));
      check($sformatf("stall_pc_%0d", k), bus.redirect_pc, (k >= 1 && k <= 3) ? 64'h4800 : 64'd0);
      check($sformatf("stall_flush_%0d", k), 64'(bus.flush_o), 64'(k <= 3));
      step();
    end
    check("stall_bcnt", 64'(bus.branch_cnt), 64'd1);
    check("stall_mcnt", 64'(bus.mispred_cnt), 64'd1);

    // pc+4 wraps to zero: correct prediction.
    do_reset();
    drive_br(64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0);
    @(negedge clk);
    check("wrap_pc_flush", 64'(bus.flush_o), 64'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("wrap_pc_rv", 64'(bus.redirect_valid), 64'd0);
    check("wrap_pc_mcnt", 64'(bus.mispred_cnt), 64'd0);

    // Mispredict counter wraps modulo 2^32.
    do_reset();
    @(negedge clk);
    force dut.mispred_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_q;
    check("cnt_preload", 64'(bus.mispred_cnt), 64'hFFFF_FFFF);
    step();
    drive_br(64'h5000, 64'h6000, 1'b0);
    exp_q.push_back(64'h6000);
    step();
    idle_inputs();
    @(negedge clk);
    check("cnt_wrap", 64'(bus.mispred_cnt), 64'd0);
    check("cnt_bcnt", 64'(bus.branch_cnt), 64'd1);
    step();
    step();

    // Reset while a redirect is pending drops it.
    do_reset();
    drive_br(64'h7000, 64'h7100, 1'b0);
    bus.redirect_ready = 1'b0;
    step();
    idle_inputs();
    bus.redirect_ready = 1'b0;
    @(negedge clk);
    check("rstredir_rv_pre", 64'(bus.redirect_valid), 64'd1);
    resetn = 1'b0;
    step();
    @(negedge clk);
    check("rstredir_rv", 64'(bus.redirect_valid), 64'd0);
    check("rstredir_busy", 64'(bus.busy_o), 64'd0);
    resetn = 1'b1;
    step();
    step();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Control-flow redirect controller for the 5-stage pipeline, sitting between execute and fetch. It consumes the resolved branch/jump outcome (branch flag plus 64-bit target) from the execute-stage target unit and compares it with the static fall-through prediction (pc+4). On a mispredict it flushes the younger IF/ID contents and holds a redirect request until fetch can accept it, never abandoning an in-flight instruction-bus transaction. It also keeps branch and mispredict statistics counters.

## Interface
- No parameters; address width fixed at 64, counters fixed at 32.
- clk  in  1  system clock; all state updates on rising edge
- resetn  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX stage holds a valid instruction
- ex_branch  in  1  EX instruction is a resolved control transfer (JAL/JALR/BZ/BNZ)
- ex_pc  in  64  PC of the EX instruction
- ex_jump  in  64  resolved next PC from the target unit
- ex_stall  in  1  EX instruction is held this cycle and stays in EX next cycle
- ibus_busy  in  1  fetch has an ibus request outstanding that must complete
- redirect_ready  in  1  fetch accepts the redirect this cycle
- flush_o  out  1  kill IF/ID contents and any fetch response this cycle
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  64  new fetch PC
- busy_o  out  1  controller not in IDLE
- branch_cnt  out  32  resolved control transfers
- mispred_cnt  out  32  mispredicted control transfers

## Operation
- Fire: F = ex_valid & ex_branch & ~done. Mispredict: M = F & (ex_jump != ex_pc + 64'd4), with 64-bit wrap on the add.
- done flag: set when F & ex_stall; cleared on any cycle with ex_stall=0. One stalled branch fires exactly once.
- States: IDLE, WAIT, REDIR.
- IDLE: M & ibus_busy -> WAIT; M & ~ibus_busy -> REDIR; else stay. On M, latch target <= ex_jump.
- WAIT: wrong-path fetch still in flight. Stay while ibus_busy=1. On ibus_busy=0 -> REDIR.
- REDIR: redirect_valid=1 and redirect_pc=target. On redirect_ready=1 -> IDLE.
- flush_o = M | (state != IDLE). It is combinational on M so the younger ID instruction is killed in the same cycle.
- busy_o = (state != IDLE).
- redirect_pc = target in REDIR; 0 otherwise.
- F arriving while state != IDLE cannot occur, because flush_o kills younger work. F is ignored in that case and a bench assertion flags it.
- Correctly predicted transfer (ex_jump == ex_pc+4): counts only, no flush, no redirect.
- Counters: branch_cnt += 1 on F; mispred_cnt += 1 on M. Both wrap modulo 2^32.

## Timing
- Reset (resetn=0 at a clk edge) forces state=IDLE, done=0, target=0, and both counters to 0.
  - All outputs are then 0 (flush_o is 0 because M is gated by ex_valid, which the pipeline holds low during reset).
  - Reset mid-WAIT or mid-REDIR drops the pending redirect.
- Mispredict with fetch idle: cycle T has M. flush_o=1 at T. redirect_valid=1 from T+1. If redirect_ready=1 at T+1, the controller is IDLE at T+2 and flush_o=0 at T+2.
- Mispredict with fetch busy: redirect_valid is first asserted the cycle after ibus_busy is sampled 0. flush_o stays 1 throughout, so the late wrong-path response is discarded.
- redirect_valid/redirect_pc are held stable until redirect_ready. There is no timeout.
- Simultaneous M and ibus_busy falling edge: ibus_busy is sampled in IDLE, so the FSM goes straight to REDIR.
- redirect_ready while redirect_valid=0: ignored.
- Minimum mispredict penalty is 2 cycles: flush cycle plus redirect cycle.

## Test plan
- Reset: hold resetn=0 3 cycles with random inputs -> all outputs 0, busy_o=0, counters 0.
- Taken JAL, ex_pc=0x8000_0000, ex_jump=0x8000_0100, ibus_busy=0, redirect_ready=1 -> flush_o=1 at T; redirect_valid=1, redirect_pc=0x8000_0100 at T+1; IDLE at T+2; branch_cnt=1, mispred_cnt=1.
- Not-taken BZ, ex_pc=0x1000, ex_jump=0x1004 -> flush_o=0, redirect_valid never 1, branch_cnt=1, mispred_cnt=0.
- Busy fetch: M with ibus_busy=1 for 4 cycles, redirect_ready=1 -> flush_o=1 for 5 cycles; redirect_valid rises the cycle after ibus_busy falls; one redirect only.
- Stalled branch: mispredict with ex_stall=1 for 3 cycles and redirect_ready=0 for 2 cycles -> exactly one redirect, branch_cnt=1, mispred_cnt=1; redirect_pc stable while waiting.
- Wrap cases:
  - ex_pc=0xFFFF_FFFF_FFFF_FFFC, ex_jump=0 -> treated as correct prediction, no redirect.
  - Preload mispred_cnt=0xFFFF_FFFF, then one mispredict -> counter wraps to 0.
  - Reset asserted in REDIR -> redirect_valid=0 next cycle.
